// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave core.
//   spi_state_t : frame FSM states (IDLE, ACTIVE)
//   spi_mode_t  : {cpol, cpha} as latched at frame start
//   MODE0..3    : standard SPI mode encodings
//   lead_edge / trail_edge : map detected sck rise/fall onto the mode's edge roles
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

    // Leading edge is the first transition away from the CPOL idle level.
    function automatic logic lead_edge(input spi_mode_t m, input logic rise, input logic fall);
        return m.cpol ? fall : rise;
    endfunction

    // Trailing edge returns sck to the CPOL idle level.
    function automatic logic trail_edge(input spi_mode_t m, input logic rise, input logic fall);
        return m.cpol ? rise : fall;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchroniser chain plus history flop for one asynchronous pin.
//   clk, reset : system clock, synchronous active-high reset
//   pin        : asynchronous input
//   level      : synchronised pin level (SYNC_STAGES clk behind the pin)
//   rise_c     : level went 0->1 this cycle (from history vs current)
//   fall_c     : level went 1->0 this cycle
// RESET_VAL is the pin's idle level so reset does not fake an edge.
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Synchroniser chain and one-deep history for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level  = sync_q[SYNC_STAGES-1];
    assign rise_c = level & ~hist_q;
    assign fall_c = ~level & hist_q;

endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: fully synchronous SPI slave, all four modes, multi-word bursts.
//   clk, reset          : system clock (>= 4x sck), synchronous active-high reset
//   sck, mosi, cs_n     : asynchronous SPI pins, oversampled through spi_pin_sync
//   mode                : {CPOL,CPHA}, latched when cs_n fall is detected
//   lsb_first           : (SPI_SLAVE_LSB_FIRST_EN only) bit order, latched with mode
//   miso, miso_oe       : serial data and output enable for the pad tristate
//   tx_data/valid/ready : TX word handshake; tx_ready pulses when a word is taken
//   rx_data/valid/ready : RX word handshake; rx_valid holds until accepted
//   tx_underrun         : pulse, a word load found tx_valid low (FILL_WORD sent)
//   rx_overrun          : pulse, a word completed while the old one was unread
//   frame_abort         : pulse, cs_n rose mid-word
//   busy                : frame active
// Optional macro SPI_SLAVE_LSB_FIRST_EN adds the lsb_first port; otherwise MSB first.
module spi_slave_core #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] FILL_WORD   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              mosi,
    input  logic              cs_n,
    input  logic [1:0]        mode,
`ifdef SPI_SLAVE_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              tx_underrun,
    output logic              rx_overrun,
    output logic              frame_abort,
    output logic              busy
);

    import spi_pkg::*;

    localparam int unsigned       CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam int unsigned       FLUSH_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

    // Next bit to drive for the current bit order.
    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    // Drop the bit just driven.
    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Pin synchronisers; reset values are the pin idle levels.
    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .pin(sck),
        .level(sck_level), .rise_c(sck_rise), .fall_c(sck_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .pin(mosi),
        .level(mosi_level), .rise_c(mosi_rise), .fall_c(mosi_fall)
    );

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .pin(cs_n),
        .level(cs_level), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    logic unused_pins;
    assign unused_pins = &{1'b0, sck_level, mosi_rise, mosi_fall};

    logic lsb_sel;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign lsb_sel = lsb_first;
`else
    assign lsb_sel = 1'b0;
`endif

    // Registered state
    spi_state_t           state_q, state_d;
    spi_mode_t            mode_q, mode_d;
    logic                 lsb_q, lsb_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]    tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]    rx_shift_q, rx_shift_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic                 armed_q, armed_d;
    logic                 miso_d, miso_oe_d, busy_d;
    logic                 tx_ready_d, tx_underrun_d, rx_overrun_d, frame_abort_d;
    logic [DATA_W-1:0]    rx_data_d;
    logic                 rx_valid_d;

    // Edge roles from the mode latched at frame start.
    logic sample_edge_c, shift_edge_c;
    always_comb begin
        sample_edge_c = mode_q.cpha ? trail_edge(mode_q, sck_rise, sck_fall)
                                    : lead_edge(mode_q, sck_rise, sck_fall);
        shift_edge_c  = mode_q.cpha ? lead_edge(mode_q, sck_rise, sck_fall)
                                    : trail_edge(mode_q, sck_rise, sck_fall);
    end

    // Next-state and datapath logic.
    logic              flushed_c;
    logic [DATA_W-1:0] load_word_c;
    logic [DATA_W-1:0] rx_word_c;
    spi_mode_t         mode_in_c;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        lsb_d         = lsb_q;
        bit_cnt_d     = bit_cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        miso_d        = miso;
        miso_oe_d     = miso_oe;
        busy_d        = busy;
        rx_data_d     = rx_data;
        rx_valid_d    = rx_valid && !rx_ready;
        tx_ready_d    = 1'b0;
        tx_underrun_d = 1'b0;
        rx_overrun_d  = 1'b0;
        frame_abort_d = 1'b0;

        // cs_n level is trusted only once the synchroniser has flushed its reset
        // value; a frame starts only from a genuine high-then-low cs_n.
        flushed_c = (flush_q == FLUSH_DONE);
        flush_d   = flushed_c ? flush_q : flush_q + FLUSH_W'(1);
        armed_d   = armed_q || (flushed_c && cs_level);

        load_word_c = tx_valid ? tx_data : FILL_WORD;
        mode_in_c   = spi_mode_t'(mode);
        rx_word_c   = lsb_q ? {mosi_level, rx_shift_q[DATA_W-1:1]}
                            : {rx_shift_q[DATA_W-2:0], mosi_level};

        case (state_q)
            IDLE: begin
                miso_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (cs_fall && armed_q) begin
                    state_d       = ACTIVE;
                    mode_d        = mode_in_c;
                    lsb_d         = lsb_sel;
                    bit_cnt_d     = LAST_BIT;
                    rx_shift_d    = '0;
                    miso_oe_d     = 1'b1;
                    busy_d        = 1'b1;
                    tx_ready_d    = tx_valid;
                    tx_underrun_d = !tx_valid;
                    // CPHA=0 needs the first bit on the wire before the first sck edge.
                    if (!mode_in_c.cpha) begin
                        miso_d     = head_bit(load_word_c, lsb_sel);
                        tx_shift_d = advance(load_word_c, lsb_sel);
                    end else begin
                        tx_shift_d = load_word_c;
                    end
                end
            end

            ACTIVE: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    miso_oe_d  = 1'b0;
                    busy_d     = 1'b0;
                    rx_shift_d = '0;
                    if (bit_cnt_q != LAST_BIT) begin
                        frame_abort_d = 1'b1;
                    end
                end else begin
                    if (sample_edge_c) begin
                        rx_shift_d = rx_word_c;
                        if (bit_cnt_q == '0) begin
                            bit_cnt_d = LAST_BIT;
                            if (!rx_valid || rx_ready) begin
                                rx_data_d  = rx_word_c;
                                rx_valid_d = 1'b1;
                            end else begin
                                rx_overrun_d = 1'b1;
                            end
                            // Pre-load unshifted; the next shift edge drives its first bit.
                            tx_shift_d    = load_word_c;
                            tx_ready_d    = tx_valid;
                            tx_underrun_d = !tx_valid;
                        end else begin
                            bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        end
                    end
                    if (shift_edge_c) begin
                        miso_d     = head_bit(tx_shift_q, lsb_q);
                        tx_shift_d = advance(tx_shift_q, lsb_q);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= '0;
            lsb_q       <= 1'b0;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            lsb_q       <= lsb_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            miso        <= miso_d;
            miso_oe     <= miso_oe_d;
            busy        <= busy_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            tx_ready    <= tx_ready_d;
            tx_underrun <= tx_underrun_d;
            rx_overrun  <= rx_overrun_d;
            frame_abort <= frame_abort_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: directed and randomized frames against an 8-bit and a 16-bit
// instance, checked against a word-level model of the SPI transfer.
module tb_spi_slave_core;

    localparam int        CLK   = 10;
    localparam int        HALF  = 40;
    localparam logic [7:0] FILL8 = 8'h00;

    typedef struct {
        bit         v;
        logic [7:0] d;
    } tx_ent_t;

    logic clk = 1'b0;
    logic reset;
    logic sck, mosi, cs8_n, cs16_n, lsb_first;
    logic [1:0] mode_pin;

    logic        miso8, miso_oe8, tx_ready8, rx_valid8, tx_underrun8, rx_overrun8, frame_abort8, busy8;
    logic [7:0]  tx_data8, rx_data8;
    logic        tx_valid8, rx_ready8;

    logic        miso16, miso_oe16, tx_ready16, rx_valid16, tx_underrun16, rx_overrun16, frame_abort16, busy16;
    logic [15:0] tx_data16, rx_data16;
    logic        tx_valid16, rx_ready16;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txr = 0, n_und = 0, n_ovr = 0, n_abort = 0;

    tx_ent_t     txq[$];
    tx_ent_t     plan[$];
    logic [7:0]  rxq[$];
    logic [7:0]  mw[4];
    logic [31:0] last_mi[4];
    bit          lsb_mode = 1'b0;

    always #(CLK/2) clk = ~clk;

    spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2), .FILL_WORD(FILL8)) dut8 (
        .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .cs_n(cs8_n), .mode(mode_pin),
`ifdef SPI_SLAVE_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .miso(miso8), .miso_oe(miso_oe8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_ready(rx_ready8),
        .tx_underrun(tx_underrun8), .rx_overrun(rx_overrun8),
        .frame_abort(frame_abort8), .busy(busy8)
    );

    spi_slave_core #(.DATA_W(16), .SYNC_STAGES(2), .FILL_WORD(16'h0000)) dut16 (
        .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .cs_n(cs16_n), .mode(mode_pin),
`ifdef SPI_SLAVE_LSB_FIRST_EN
        .lsb_first(1'b0),
`endif
        .miso(miso16), .miso_oe(miso_oe16),
        .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_ready(rx_ready16),
        .tx_underrun(tx_underrun16), .rx_overrun(rx_overrun16),
        .frame_abort(frame_abort16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // TX feeder and event monitor for the 8-bit instance, on the falling edge.
    initial begin
        tx_valid8 = 1'b0;
        tx_data8  = '0;
        forever begin
            @(negedge clk);
            n_txr   += int'(tx_ready8);
            n_und   += int'(tx_underrun8);
            n_ovr   += int'(rx_overrun8);
            n_abort += int'(frame_abort8);
            if ((tx_ready8 || tx_underrun8) && txq.size() > 0) void'(txq.pop_front());
            if (rx_valid8 && rx_ready8) rxq.push_back(rx_data8);
            if (txq.size() > 0) begin
                tx_valid8 = txq[0].v;
                tx_data8  = txq[0].d;
            end else begin
                tx_valid8 = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    // Bit-level SPI master; word k bit order follows lsb.
    task automatic spi_frame(input bit sel16, input int width, input int nbits, input logic [1:0] m,
                             input bit lsb, input logic [31:0] mo[4], input bit raise_cs,
                             output logic [31:0] mi[4]);
        int k, j, pos;
        for (int i = 0; i < 4; i++) mi[i] = '0;
        mode_pin = m;
        sck      = m[1];
        cs8_n    = 1'b1;
        cs16_n   = 1'b1;
        #(CLK*8);
        if (sel16) cs16_n = 1'b0; else cs8_n = 1'b0;
        #(HALF*2);
        for (int b = 0; b < nbits; b++) begin
            k   = b / width;
            j   = b % width;
            pos = lsb ? j : width - 1 - j;
            if (!m[0]) begin
                mosi = mo[k][pos];
                #HALF;
                sck = ~m[1];
                mi[k][pos] = sel16 ? miso16 : miso8;
                #HALF;
                sck = m[1];
            end else begin
                sck  = ~m[1];
                mosi = mo[k][pos];
                #HALF;
                sck = m[1];
                mi[k][pos] = sel16 ? miso16 : miso8;
                #HALF;
            end
        end
        #HALF;
        if (raise_cs) begin
            cs8_n  = 1'b1;
            cs16_n = 1'b1;
        end
    endtask

    // One complete n-word frame on the 8-bit instance using plan[] and mw[].
    task automatic run_frame8(input int n, input logic [1:0] m, input bit rdy);
        logic [31:0] mo[4];
        logic [31:0] mi[4];
        int txr0, und0, ovr0, ab0, exp_txr, exp_rx;
        logic [7:0] exp_w;
        for (int k = 0; k < 4; k++) mo[k] = 32'(mw[k]);
        txq = plan;
        rxq.delete();
        rx_ready8 = rdy;
        txr0 = n_txr; und0 = n_und; ovr0 = n_ovr; ab0 = n_abort;
        #(CLK*2);
        spi_frame(1'b0, 8, 8*n, m, lsb_mode, mo, 1'b1, mi);
        last_mi = mi;
        #(CLK*8);
        // Model: n+1 word loads (the last is a discarded pre-load).
        exp_txr = 0;
        for (int i = 0; i <= n; i++) if (i < plan.size() && plan[i].v) exp_txr++;
        for (int k = 0; k < n; k++) begin
            exp_w = (k < plan.size() && plan[k].v) ? plan[k].d : FILL8;
            check("miso_word", mi[k], 32'(exp_w));
        end
        check("tx_ready_cnt", 32'(n_txr - txr0), 32'(exp_txr));
        check("underrun_cnt", 32'(n_und - und0), 32'(n + 1 - exp_txr));
        check("overrun_cnt", 32'(n_ovr - ovr0), rdy ? 32'd0 : 32'(n - 1));
        check("abort_cnt", 32'(n_abort - ab0), 32'd0);
        if (!rdy) begin
            check("rx_valid_held", 32'(rx_valid8), 32'd1);
            check("rx_data_held", 32'(rx_data8), 32'(mw[0]));
            rx_ready8 = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
        rx_ready8 = 1'b0;
        exp_rx = rdy ? n : 1;
        check("rx_count", 32'(rxq.size()), 32'(exp_rx));
        for (int k = 0; k < rxq.size() && k < exp_rx; k++) check("rx_word", 32'(rxq[k]), 32'(mw[k]));
        check("rx_valid_drained", 32'(rx_valid8), 32'd0);
        txq.delete();
    endtask

    initial begin
        logic [31:0] mo[4];
        logic [31:0] mi[4];
        int n, ab0, txr0;
        logic [1:0] m;
        bit rdy;

        reset = 1'b1;
        sck = 1'b0; mosi = 1'b0; cs8_n = 1'b1; cs16_n = 1'b1; mode_pin = 2'b00; lsb_first = 1'b0;
        rx_ready8 = 1'b0; rx_ready16 = 1'b0;
        tx_valid16 = 1'b1; tx_data16 = 16'hBEEF;
        #2;
        repeat (5) @(posedge clk);
        #1;
        check("rst_miso", 32'(miso8), 32'd0);
        check("rst_miso_oe", 32'(miso_oe8), 32'd0);
        check("rst_tx_ready", 32'(tx_ready8), 32'd0);
        check("rst_rx_valid", 32'(rx_valid8), 32'd0);
        check("rst_rx_data", 32'(rx_data8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_pulses", 32'({tx_underrun8, rx_overrun8, frame_abort8}), 32'd0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Mode 0, A5 out, 3C in, no second TX word.
        plan.delete();
        plan.push_back('{v: 1'b1, d: 8'hA5});
        mw[0] = 8'h3C;
        run_frame8(1, 2'b00, 1'b0);

        // 16-bit instance in every mode.
        for (int md = 0; md < 4; md++) begin
            for (int k = 0; k < 4; k++) mo[k] = '0;
            mo[0] = 32'h1234;
            spi_frame(1'b1, 16, 16, 2'(md), 1'b0, mo, 1'b1, mi);
            #(CLK*8);
            check("m16_miso", mi[0], 32'hBEEF);
            check("m16_rx_valid", 32'(rx_valid16), 32'd1);
            check("m16_rx_data", 32'(rx_data16), 32'h1234);
            rx_ready16 = 1'b1;
            @(posedge clk);
            #1;
            rx_ready16 = 1'b0;
        end

        // Burst of 3 with consumer stalled and a TX gap on word 3.
        plan.delete();
        plan.push_back('{v: 1'b1, d: 8'h11});
        plan.push_back('{v: 1'b1, d: 8'h22});
        plan.push_back('{v: 1'b0, d: 8'h33});
        plan.push_back('{v: 1'b1, d: 8'h44});
        mw[0] = 8'hC1; mw[1] = 8'hC2; mw[2] = 8'hC3;
        run_frame8(3, 2'b00, 1'b0);

        // Abort after 5 of 8 bits.
        plan.delete();
        plan.push_back('{v: 1'b1, d: 8'hA5});
        plan.push_back('{v: 1'b1, d: 8'h5A});
        txq = plan;
        rxq.delete();
        ab0 = n_abort; txr0 = n_txr;
        for (int k = 0; k < 4; k++) mo[k] = 32'h6B;
        #(CLK*2);
        spi_frame(1'b0, 8, 5, 2'b00, 1'b0, mo, 1'b1, mi);
        repeat (4) @(posedge clk);
        #1;
        check("abort_miso_oe", 32'(miso_oe8), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_pulse_cnt", 32'(n_abort - ab0), 32'd1);
        check("abort_rx_valid", 32'(rx_valid8), 32'd0);
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_tx_ready_cnt", 32'(n_txr - txr0), 32'd1);
        txq.delete();

        // Random frames against the model.
        for (int f = 0; f < 8; f++) begin
            n   = int'($urandom_range(1, 3));
            m   = 2'($urandom_range(0, 3));
            rdy = 1'($urandom_range(0, 1));
            plan.delete();
            for (int i = 0; i <= n; i++) plan.push_back('{v: ($urandom_range(0, 3) != 0), d: 8'($urandom)});
            for (int k = 0; k < 4; k++) mw[k] = 8'($urandom);
            run_frame8(n, m, rdy);
        end

        // Reset in the middle of word 2, then a clean frame.
        plan.delete();
        for (int i = 0; i < 3; i++) plan.push_back('{v: 1'b1, d: 8'(8'h71 + i)});
        txq = plan;
        rxq.delete();
        rx_ready8 = 1'b0;
        for (int k = 0; k < 4; k++) mo[k] = 32'(8'h90 + k);
        #(CLK*2);
        spi_frame(1'b0, 8, 12, 2'b00, 1'b0, mo, 1'b0, mi);
        check("pre_rst_busy", 32'(busy8), 32'd1);
        check("pre_rst_rx_valid", 32'(rx_valid8), 32'd1);
        check("pre_rst_rx_data", 32'(rx_data8), 32'h90);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_miso", 32'(miso8), 32'd0);
        check("mid_rst_miso_oe", 32'(miso_oe8), 32'd0);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid8), 32'd0);
        check("mid_rst_rx_data", 32'(rx_data8), 32'd0);
        check("mid_rst_pulses", 32'({tx_ready8, tx_underrun8, rx_overrun8, frame_abort8}), 32'd0);
        reset = 1'b0;
        txq.delete();
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy8), 32'd0);
        plan.delete();
        plan.push_back('{v: 1'b1, d: 8'h5A});
        mw[0] = 8'h5A;
        run_frame8(1, 2'b00, 1'b1);

`ifdef SPI_SLAVE_LSB_FIRST_EN
        // LSB-first: 01 out shows a 1 first, 80 sent LSB-first lands as 80.
        lsb_mode  = 1'b1;
        lsb_first = 1'b1;
        plan.delete();
        plan.push_back('{v: 1'b1, d: 8'h01});
        mw[0] = 8'h80;
        run_frame8(1, 2'b00, 1'b1);
        check("lsb_first_bit", 32'(last_mi[0][0]), 32'd1);
        lsb_mode  = 1'b0;
        lsb_first = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
